// File: rtl/key_event_decoder_pkg.sv
// Shared types for the key event decoder: event and FSM encodings.
// The event word is {type, code} and travels through the FIFO as-is.
package key_evt_pkg;

    typedef enum logic [1:0] {
        EV_PRESS   = 2'b00,
        EV_REPEAT  = 2'b01,
        EV_RELEASE = 2'b10
    } ev_type_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PRESSED = 2'b01,
        HELD    = 2'b10
    } fsm_state_e;

    localparam int EV_W = 6;

    typedef struct packed {
        ev_type_e   ev_type;
        logic [3:0] code;
    } key_ev_t;

    function automatic key_ev_t mk_ev(ev_type_e t, logic [3:0] c);
        key_ev_t e;
        e.ev_type = t;
        e.code    = c;
        return e;
    endfunction

endpackage

// File: rtl/key_event_decoder_if.sv
// Event handshake between the decoder (master) and the
// time-setting controller (slave).
interface key_event_decoder_if;

    logic       ev_valid;
    logic       ev_ready;
    logic [3:0] ev_code;
    logic [1:0] ev_type;

    modport master (
        output ev_valid,
        output ev_code,
        output ev_type,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_code,
        input  ev_type,
        output ev_ready
    );

endinterface

// File: rtl/key_event_decoder_fifo.sv
// First-word-fall-through event FIFO with sticky drop flag.
// Pointers carry one extra MSB so full and empty are distinguishable.
module key_event_fifo
    import key_evt_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    i_push,
    input  key_ev_t i_data,
    input  logic    i_pop,
    output logic    o_empty,
    output key_ev_t o_head,
    output logic    o_overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;
    logic [EV_W-1:0] r_mem [DEPTH];
    logic            r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_accept;

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop    = i_pop && !w_empty;
    // A pop in the same cycle frees the slot the push needs.
    assign w_accept = i_push && (!w_full || w_pop);

    // Storage, pointers and drop flag; a push never bypasses to the head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_data;
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (i_push && !w_accept) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_empty    = w_empty;
    assign o_head     = key_ev_t'(r_mem[r_rd_ptr[AW-1:0]]);
    assign o_overflow = r_overflow;

endmodule

// File: rtl/key_event_decoder.sv
// Scanner key level -> synchronised, debounced PRESS/REPEAT/RELEASE
// events with auto-repeat, buffered behind a valid/ready FIFO.
module key_event_decoder
    import key_evt_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int LONG_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       key_valid,
    input  logic [3:0]                 key_code,
    key_event_decoder_if.master        ev,
    output logic                       key_down,
    output logic                       long_hold,
    output logic                       overflow
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ?
                        $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = (LONG_CYCLES > 1) ?
                        $clog2(LONG_CYCLES) : 1;

    localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] T_LONG  = TW'(LONG_CYCLES - 1);
    localparam logic [TW-1:0] T_REP   = TW'(REPEAT_CYCLES - 1);

    logic       r_sync1_valid;
    logic       r_sync2_valid;
    logic [3:0] r_sync1_code;
    logic [3:0] r_sync2_code;

    logic          r_cand_valid;
    logic [3:0]    r_cand_code;
    logic [DW-1:0] r_deb_cnt;
    logic          r_deb_valid;
    logic [3:0]    r_deb_code;

    fsm_state_e    r_state;
    logic [TW-1:0] r_timer;
    logic [3:0]    r_cur_code;
    logic          r_push;
    key_ev_t       r_push_ev;
    logic          r_long_hold;

    logic          w_cand_valid;
    logic [3:0]    w_cand_code;
    logic          w_cand_chg;
    logic [DW-1:0] w_deb_inc;
    logic          w_deb_hit;
    logic          w_drop;
    logic          w_empty;
    key_ev_t       w_head;
    logic          w_overflow;

    // Two-flop synchroniser for the asynchronous scanner outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1_valid <= 1'b0;
            r_sync2_valid <= 1'b0;
            r_sync1_code  <= '0;
            r_sync2_code  <= '0;
        end else begin
            r_sync1_valid <= key_valid;
            r_sync2_valid <= r_sync1_valid;
            r_sync1_code  <= key_code;
            r_sync2_code  <= r_sync1_code;
        end
    end

    // The code is meaningless while no key is held, so it is masked.
    assign w_cand_valid = r_sync2_valid;
    assign w_cand_code  = r_sync2_valid ? r_sync2_code : 4'h0;
    assign w_cand_chg   = {w_cand_valid, w_cand_code} !=
                          {r_cand_valid, r_cand_code};
    assign w_deb_inc    = r_deb_cnt + DW'(1);
    // Load as the counter steps onto its terminal value (or sits there).
    assign w_deb_hit    = !w_cand_chg &&
                          ((r_deb_cnt == DEB_MAX) || (w_deb_inc == DEB_MAX));

    // Debounce: accept the candidate once it has stayed unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cand_valid <= 1'b0;
            r_cand_code  <= '0;
            r_deb_cnt    <= '0;
            r_deb_valid  <= 1'b0;
            r_deb_code   <= '0;
        end else begin
            r_cand_valid <= w_cand_valid;
            r_cand_code  <= w_cand_code;
            if (w_cand_chg) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt != DEB_MAX) begin
                r_deb_cnt <= w_deb_inc;
            end
            if (w_deb_hit) begin
                r_deb_valid <= w_cand_valid;
                r_deb_code  <= w_cand_code;
            end
        end
    end

    // Release and code change both end the current key.
    assign w_drop = !r_deb_valid || (r_deb_code != r_cur_code);

    // Event FSM; one shared timer measures hold and repeat intervals.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_cur_code  <= '0;
            r_push      <= 1'b0;
            r_push_ev   <= '0;
            r_long_hold <= 1'b0;
        end else begin
            r_push  <= 1'b0;
            r_timer <= r_timer + TW'(1);
            unique case (r_state)
                IDLE: begin
                    if (r_deb_valid) begin
                        r_push     <= 1'b1;
                        r_push_ev  <= mk_ev(EV_PRESS, r_deb_code);
                        r_cur_code <= r_deb_code;
                        r_timer    <= '0;
                        r_state    <= PRESSED;
                    end
                end
                PRESSED: begin
                    if (w_drop) begin
                        r_push    <= 1'b1;
                        r_push_ev <= mk_ev(EV_RELEASE, r_cur_code);
                        r_state   <= IDLE;
                    end else if (r_timer == T_LONG) begin
                        r_push      <= 1'b1;
                        r_push_ev   <= mk_ev(EV_REPEAT, r_cur_code);
                        r_timer     <= '0;
                        r_state     <= HELD;
                        r_long_hold <= 1'b1;
                    end
                end
                HELD: begin
                    if (w_drop) begin
                        r_push      <= 1'b1;
                        r_push_ev   <= mk_ev(EV_RELEASE, r_cur_code);
                        r_state     <= IDLE;
                        r_long_hold <= 1'b0;
                    end else if (r_timer == T_REP) begin
                        r_push    <= 1'b1;
                        r_push_ev <= mk_ev(EV_REPEAT, r_cur_code);
                        r_timer   <= '0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_long_hold <= 1'b0;
                end
            endcase
        end
    end

    key_event_fifo #(
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (r_push),
        .i_data     (r_push_ev),
        .i_pop      (ev.ev_ready),
        .o_empty    (w_empty),
        .o_head     (w_head),
        .o_overflow (w_overflow)
    );

    assign ev.ev_valid = !w_empty;
    assign ev.ev_code  = w_head.code;
    assign ev.ev_type  = w_head.ev_type;
    assign key_down    = r_deb_valid;
    assign long_hold   = r_long_hold;
    assign overflow    = w_overflow;

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: segment table, hand sequences and
// random stimulus against a cycle-level reference model.
module tb_key_event_decoder;
    import key_evt_pkg::*;

    localparam int DEB   = 4;
    localparam int LONG  = 20;
    localparam int REP   = 8;
    localparam int DEPTH = 4;
    localparam int HN    = DEB + 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_down;
    logic       long_hold;
    logic       overflow;

    key_event_decoder_if ev();

    key_event_decoder #(
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LONG),
        .REPEAT_CYCLES   (REP),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .key_valid (key_valid),
        .key_code  (key_code),
        .ev        (ev),
        .key_down  (key_down),
        .long_hold (long_hold),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [4:0] m_hist [HN];
    logic       m_dv;
    logic [3:0] m_dc;
    bit         m_held;
    logic [3:0] m_code;
    int         m_t0;
    int         m_cyc;
    bit         m_pend;
    logic [5:0] m_pend_ev;
    logic [5:0] m_q[$];
    bit         m_ovf;
    bit         m_long;

    logic [5:0] ev_log[$];
    logic [5:0] xq[$];

    typedef struct {
        logic       kv;
        logic [3:0] code;
        logic       rdy;
        int         ncyc;
        logic       exp_down;
        logic       exp_long;
        logic       exp_ovf;
        int         exp_first;
    } seg_t;

    seg_t tbl[18];

    function automatic logic [5:0] mk(logic [1:0] t, logic [3:0] c);
        return {t, c};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < HN; i++) m_hist[i] = '0;
        m_dv = 1'b0;
        m_dc = '0;
        m_held = 0;
        m_code = '0;
        m_pend = 0;
        m_q.delete();
        m_ovf = 0;
        m_long = 0;
    endtask

    // Behaviour at one rising edge, using values present before it.
    task automatic model_edge();
        int  sz;
        bit  pop;
        bit  eq;
        int  e;
        m_cyc++;
        if (reset) begin
            model_reset();
            return;
        end
        sz = m_q.size();
        pop = (sz > 0) && ev.ev_ready;
        if (pop) void'(m_q.pop_front());
        if (m_pend) begin
            if (sz < DEPTH || pop) m_q.push_back(m_pend_ev);
            else m_ovf = 1;
        end
        m_pend = 0;
        if (!m_held) begin
            if (m_dv) begin
                m_pend = 1;
                m_pend_ev = mk(EV_PRESS, m_dc);
                m_held = 1;
                m_code = m_dc;
                m_t0 = m_cyc;
            end
        end else if (!m_dv || m_dc != m_code) begin
            m_pend = 1;
            m_pend_ev = mk(EV_RELEASE, m_code);
            m_held = 0;
        end else begin
            e = m_cyc - m_t0;
            if (e >= LONG && (e - LONG) % REP == 0) begin
                m_pend = 1;
                m_pend_ev = mk(EV_REPEAT, m_code);
            end
        end
        m_long = m_held && (m_cyc - m_t0) >= LONG;
        for (int i = HN - 1; i > 0; i--) m_hist[i] = m_hist[i - 1];
        m_hist[0] = {key_valid, key_valid ? key_code : 4'h0};
        eq = 1;
        for (int i = 3; i < HN; i++) if (m_hist[i] != m_hist[2]) eq = 0;
        if (eq) {m_dv, m_dc} = m_hist[2];
    endtask

    task automatic check_model();
        logic       exp_v;
        logic [5:0] exp_e;
        logic [5:0] got_e;
        bit         bad;
        exp_v = (m_q.size() > 0);
        exp_e = 6'h0;
        if (exp_v) exp_e = m_q[0];
        got_e = {ev.ev_type, ev.ev_code};
        bad = (ev.ev_valid !== exp_v) || (exp_v && got_e !== exp_e) ||
              (key_down !== m_dv) || (long_hold !== m_long) ||
              (overflow !== m_ovf);
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL model cyc=%0d got v=%b ev=%h kd=%b lh=%b ov=%b req v=%b ev=%h kd=%b lh=%b ov=%b",
                     m_cyc, ev.ev_valid, got_e, key_down, long_hold, overflow,
                     exp_v, exp_e, m_dv, m_long, m_ovf);
        end
    endtask

    task automatic chk(string name, int got, int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic step();
        if (ev.ev_valid && ev.ev_ready)
            ev_log.push_back({ev.ev_type, ev.ev_code});
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic chk_log(string name);
        int n;
        chk($sformatf("%s count", name), ev_log.size(), xq.size());
        n = (ev_log.size() < xq.size()) ? ev_log.size() : xq.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s ev%0d", name, i), int'(ev_log[i]), int'(xq[i]));
        ev_log.delete();
    endtask

    task automatic run_segs(int lo, int hi);
        for (int s = lo; s <= hi; s++) begin
            int first = 0;
            key_valid = tbl[s].kv;
            key_code = tbl[s].code;
            ev.ev_ready = tbl[s].rdy;
            for (int k = 1; k <= tbl[s].ncyc; k++) begin
                step();
                if (first == 0 && ev.ev_valid) first = k;
            end
            chk($sformatf("seg%0d key_down", s), int'(key_down), int'(tbl[s].exp_down));
            chk($sformatf("seg%0d long_hold", s), int'(long_hold), int'(tbl[s].exp_long));
            chk($sformatf("seg%0d overflow", s), int'(overflow), int'(tbl[s].exp_ovf));
            if (tbl[s].exp_first >= 0)
                chk($sformatf("seg%0d first_valid", s), first, tbl[s].exp_first);
        end
    endtask

    initial begin
        int lat;
        // kv, code, rdy, ncyc, down, long, ovf, first ev_valid step
        tbl[0]  = '{1'b1, 4'h5, 1'b1, 10, 1'b1, 1'b0, 1'b0, 8};
        tbl[1]  = '{1'b0, 4'h0, 1'b1, 12, 1'b0, 1'b0, 1'b0, 8};
        tbl[2]  = '{1'b1, 4'h7, 1'b1, 2,  1'b0, 1'b0, 1'b0, 0};
        tbl[3]  = '{1'b0, 4'h0, 1'b1, 2,  1'b0, 1'b0, 1'b0, 0};
        tbl[4]  = '{1'b1, 4'h7, 1'b1, 2,  1'b0, 1'b0, 1'b0, 0};
        tbl[5]  = '{1'b0, 4'h0, 1'b1, 2,  1'b0, 1'b0, 1'b0, 0};
        tbl[6]  = '{1'b1, 4'h7, 1'b1, 2,  1'b0, 1'b0, 1'b0, 0};
        tbl[7]  = '{1'b0, 4'h0, 1'b1, 2,  1'b0, 1'b0, 1'b0, 0};
        tbl[8]  = '{1'b0, 4'h0, 1'b1, 10, 1'b0, 1'b0, 1'b0, 0};
        tbl[9]  = '{1'b1, 4'hA, 1'b1, 26, 1'b1, 1'b0, 1'b0, 8};
        tbl[10] = '{1'b1, 4'hA, 1'b1, 24, 1'b1, 1'b1, 1'b0, -1};
        tbl[11] = '{1'b0, 4'h0, 1'b1, 20, 1'b0, 1'b0, 1'b0, -1};
        tbl[12] = '{1'b1, 4'h3, 1'b1, 15, 1'b1, 1'b0, 1'b0, 8};
        tbl[13] = '{1'b1, 4'hC, 1'b1, 15, 1'b1, 1'b0, 1'b0, -1};
        tbl[14] = '{1'b0, 4'h0, 1'b1, 15, 1'b0, 1'b0, 1'b0, 8};
        tbl[15] = '{1'b1, 4'hA, 1'b0, 50, 1'b1, 1'b1, 1'b0, 8};
        tbl[16] = '{1'b0, 4'h0, 1'b0, 20, 1'b0, 1'b0, 1'b1, -1};
        tbl[17] = '{1'b0, 4'h0, 1'b1, 10, 1'b0, 1'b0, 1'b1, 1};

        m_cyc = 0;
        model_reset();
        reset = 1'b1;
        key_valid = 1'b0;
        key_code = 4'h0;
        ev.ev_ready = 1'b1;
        step();
        step();
        chk("reset ev_valid", int'(ev.ev_valid), 0);
        chk("reset ev_code", int'(ev.ev_code), 0);
        chk("reset ev_type", int'(ev.ev_type), 0);
        chk("reset key_down", int'(key_down), 0);
        chk("reset long_hold", int'(long_hold), 0);
        chk("reset overflow", int'(overflow), 0);
        reset = 1'b0;

        run_segs(0, 1);
        xq = {mk(EV_PRESS, 4'h5), mk(EV_RELEASE, 4'h5)};
        chk_log("clean");

        run_segs(2, 8);
        xq = {};
        chk_log("bounce");

        run_segs(9, 11);
        xq = {mk(EV_PRESS, 4'hA), mk(EV_REPEAT, 4'hA), mk(EV_REPEAT, 4'hA),
              mk(EV_REPEAT, 4'hA), mk(EV_REPEAT, 4'hA), mk(EV_RELEASE, 4'hA)};
        chk_log("long");

        run_segs(12, 14);
        xq = {mk(EV_PRESS, 4'h3), mk(EV_RELEASE, 4'h3),
              mk(EV_PRESS, 4'hC), mk(EV_RELEASE, 4'hC)};
        chk_log("codechg");

        run_segs(15, 17);
        xq = {mk(EV_PRESS, 4'hA), mk(EV_REPEAT, 4'hA),
              mk(EV_REPEAT, 4'hA), mk(EV_REPEAT, 4'hA)};
        chk_log("backpr");

        // Reset while HELD, key kept down throughout.
        key_valid = 1'b1;
        key_code = 4'hA;
        ev.ev_ready = 1'b1;
        for (int k = 0; k < 30; k++) step();
        chk("hold long_hold", int'(long_hold), 1);
        reset = 1'b1;
        #1;
        chk("async ev_valid", int'(ev.ev_valid), 0);
        chk("async key_down", int'(key_down), 0);
        chk("async long_hold", int'(long_hold), 0);
        chk("async overflow", int'(overflow), 0);
        step();
        step();
        reset = 1'b0;
        ev_log.delete();
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (ev.ev_valid) begin
                lat = k;
                break;
            end
        end
        chk("rst press latency", lat, DEB + 4);
        chk("rst press event", int'({ev.ev_type, ev.ev_code}),
            int'(mk(EV_PRESS, 4'hA)));
        key_valid = 1'b0;
        for (int k = 0; k < 15; k++) step();
        xq = {mk(EV_PRESS, 4'hA), mk(EV_RELEASE, 4'hA)};
        chk_log("rst");

        // Random segments checked cycle by cycle against the model.
        for (int s = 0; s < 60; s++) begin
            int len;
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
            end
            key_valid = ($urandom_range(0, 2) != 0);
            key_code = 4'($urandom_range(0, 15));
            ev.ev_ready = ($urandom_range(0, 3) != 0);
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 60)
                                               : $urandom_range(1, 12);
            for (int k = 0; k < len; k++) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
